// File: rtl/student_coeff_reader.sv
// Read-side sequencer for the coefficient dual-port RAM. Fetches num_taps
// coefficients starting at base_addr, absorbs the RAM's one-cycle read
// latency in a 2-entry FIFO and streams them to the MAC over valid/ready.
module student_coeff_reader #(
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned CoeffDataSize = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [AddrWidth-1:0]     base_addr_i,
  input  logic [AddrWidth:0]       num_taps_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     enb_o,
  output logic [AddrWidth-1:0]     addrb_o,
  input  logic [CoeffDataSize-1:0] dob_i,
  output logic [CoeffDataSize-1:0] coeff_o,
  output logic                     coeff_valid_o,
  input  logic                     coeff_ready_i,
  output logic                     coeff_last_o,
  output logic [AddrWidth-1:0]     coeff_idx_o
);

  localparam int unsigned CntWidth = AddrWidth + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } state_e;

  state_e                  state_q, state_d;
  logic [CntWidth-1:0]     num_taps_q, num_taps_d;
  logic [CntWidth-1:0]     issued_q, issued_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic                    inflight_q, inflight_d;
  logic [AddrWidth-1:0]    inflight_idx_q, inflight_idx_d;

  logic [CoeffDataSize-1:0] fifo_data_q [2];
  logic [CoeffDataSize-1:0] fifo_data_d [2];
  logic [AddrWidth-1:0]     fifo_idx_q  [2];
  logic [AddrWidth-1:0]     fifo_idx_d  [2];
  logic [1:0]               fifo_last_q, fifo_last_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               count_q, count_d;

  logic                     pop;
  logic                     push;
  logic                     enb;
  logic [2:0]               occupancy;
  logic [CntWidth-1:0]      last_idx;

  assign coeff_valid_o = (count_q != 2'd0);
  assign coeff_o       = fifo_data_q[rd_ptr_q];
  assign coeff_idx_o   = fifo_idx_q[rd_ptr_q];
  assign coeff_last_o  = fifo_last_q[rd_ptr_q];
  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StFinish);
  assign enb_o         = enb;
  assign addrb_o       = addr_q;

  assign pop      = coeff_valid_o & coeff_ready_i;
  assign push     = inflight_q;
  assign last_idx = num_taps_q - CntWidth'(1);

  // Next-state, read-issue and FIFO bookkeeping.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    num_taps_d     = num_taps_q;
    issued_d       = issued_q;
    addr_d         = addr_q;
    inflight_idx_d = inflight_idx_q;
    fifo_data_d    = fifo_data_q;
    fifo_idx_d     = fifo_idx_q;
    fifo_last_d    = fifo_last_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;

    // Entries held plus the read still on its way, minus what leaves this
    // cycle, must stay below 2 for a new read to have a guaranteed slot.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    enb       = (state_q == StRun) && (issued_q < num_taps_q) && (occupancy < 3'd2);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d     = base_addr_i;
          num_taps_d = num_taps_i;
          issued_d   = '0;
          state_d    = (num_taps_i == '0) ? StFinish : StRun;
        end
      end
      StRun: begin
        if (pop && coeff_last_o) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Issue: the address pointer wraps naturally at 2**AddrWidth.
    if (enb) begin
      addr_d         = addr_q + AddrWidth'(1);
      issued_d       = issued_q + CntWidth'(1);
      inflight_idx_d = issued_q[AddrWidth-1:0];
    end
    inflight_d = enb;

    if (push) begin
      fifo_data_d[wr_ptr_q] = dob_i;
      fifo_idx_d[wr_ptr_q]  = inflight_idx_q;
      fifo_last_d[wr_ptr_q] = ({1'b0, inflight_idx_q} == last_idx);
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // State register; reset aborts any sequence and discards in-flight data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      num_taps_q     <= '0;
      issued_q       <= '0;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      // NOTE: the two FIFO entries are reset so the head outputs read 0 after reset.
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      fifo_last_q    <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q        <= state_d;
      num_taps_q     <= num_taps_d;
      issued_q       <= issued_d;
      addr_q         <= addr_d;
      inflight_q     <= inflight_d;
      inflight_idx_q <= inflight_idx_d;
      fifo_data_q    <= fifo_data_d;
      fifo_idx_q     <= fifo_idx_d;
      fifo_last_q    <= fifo_last_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
    end
  end

endmodule

// File: tb/tb_student_coeff_reader.sv
// Self-checking bench for student_coeff_reader: table of runs plus hand-written
// reset-mid-run sequence, with scoreboard queues for coefficients and addresses.
module tb_student_coeff_reader;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_taps = '0;
  logic          busy_o, done_o, enb_o, coeff_valid_o, coeff_last_o;
  logic [AW-1:0] addrb_o, coeff_idx_o;
  logic [DW-1:0] dob, coeff_o;
  logic          ready = 1'b1;

  student_coeff_reader #(.AddrWidth(AW), .CoeffDataSize(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start), .base_addr_i(base_addr),
    .num_taps_i(num_taps), .busy_o(busy_o), .done_o(done_o), .enb_o(enb_o),
    .addrb_o(addrb_o), .dob_i(dob), .coeff_o(coeff_o), .coeff_valid_o(coeff_valid_o),
    .coeff_ready_i(ready), .coeff_last_o(coeff_last_o), .coeff_idx_o(coeff_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: one-cycle registered read port.
  logic [DW-1:0] mem [1024];
  always @(posedge clk_i) if (enb_o) dob <= mem[addrb_o];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboards: expected {coeff, idx, last} and expected read addresses.
  logic [DW+AW:0] exp_q[$];
  logic [AW-1:0]  addr_q[$];

  // Monitor state.
  int            hs_cnt = 0, enb_cnt = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0;
  logic [AW-1:0] last_addr = '0;
  int            occ = 0;
  logic          infl = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW+AW:0] stall_word = '0;

  // Samples on the falling edge: handshakes, reads, done/busy, FIFO occupancy model.
  always @(negedge clk_i) begin
    automatic logic [DW+AW:0] word = {coeff_o, coeff_idx_o, coeff_last_o};
    automatic logic           pop  = coeff_valid_o && ready;
    automatic int             occ_next;
    if (!rst_ni) begin
      occ        <= 0;
      infl       <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      check("valid_vs_occupancy", coeff_valid_o, occ != 0);
      if (done_o) begin
        check("busy_low_in_finish", busy_o, 1'b0);
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy_o) busy_cnt <= busy_cnt + 1;
      if (prev_stall) check("stall_hold", word, stall_word);
      if (pop) begin
        check("coeff_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("coeff_hs", word, exp_q.pop_front());
        hs_cnt <= hs_cnt + 1;
      end
      if (enb_o) begin
        check("read_expected", addr_q.size() > 0, 1'b1);
        if (addr_q.size() > 0) check("read_addr", addrb_o, addr_q.pop_front());
        enb_cnt   <= enb_cnt + 1;
        last_addr <= addrb_o;
      end
      occ_next = occ + int'(infl) - int'(pop);
      check("fifo_no_overflow", occ_next <= 2, 1'b1);
      occ        <= occ_next;
      infl       <= enb_o;
      prev_stall <= coeff_valid_o && !ready;
      stall_word <= word;
    end
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   taps;
    bit            rnd;           // random backpressure
    int            pulse_at;      // loop step of a stray start pulse, -1 none
    int            exp_done;      // done cycle relative to start, -1 unchecked
    int            exp_busy;      // busy cycles, -1 unchecked
    logic [AW-1:0] exp_last_addr; // last address read
  } vec_t;

  task automatic push_expected(input logic [AW-1:0] base, input logic [AW:0] taps);
    for (int i = 0; i < int'(taps); i++) begin
      automatic logic [AW-1:0] a = base + AW'(i);
      exp_q.push_back({mem[a], AW'(i), i == int'(taps) - 1});
      addr_q.push_back(a);
    end
  endtask

  task automatic run_seq(input vec_t v);
    int d0, h0, e0, b0, start_cyc, budget;
    bit seen;
    d0 = done_cnt; h0 = hs_cnt; e0 = enb_cnt; b0 = busy_cnt;
    push_expected(v.base, v.taps);
    @(posedge clk_i); #1;
    base_addr = v.base; num_taps = v.taps; start = 1'b1;
    ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    #5 start_cyc = cyc;
    budget = 8 * int'(v.taps) + 40;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk_i); #1;
      start     = (k == v.pulse_at);
      base_addr = AW'($urandom);
      num_taps  = (k == v.pulse_at) ? 11'd3 : 11'($urandom);
      if (v.rnd) ready = 1'($urandom_range(0, 1));
      #5 seen = (done_cnt != d0);
    end
    start = 1'b0;
    check("done_seen", seen, 1'b1);
    if (v.exp_done >= 0) check("done_latency", done_cyc - start_cyc, v.exp_done);
    repeat (8) @(posedge clk_i);
    #6;
    check("done_once", done_cnt - d0, 1);
    check("handshakes", hs_cnt - h0, int'(v.taps));
    check("reads", enb_cnt - e0, int'(v.taps));
    if (v.exp_busy >= 0) check("busy_cycles", busy_cnt - b0, v.exp_busy);
    if (v.taps != 0) check("last_addr", last_addr, v.exp_last_addr);
    check("scoreboard_drained", exp_q.size() + addr_q.size(), 0);
  endtask

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, h0;
    bit hit;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);

    vecs[0] = '{base: 10'd0,    taps: 11'd4,    rnd: 1'b0, pulse_at: -1, exp_done: 7,    exp_busy: 6,    exp_last_addr: 10'd3};
    vecs[1] = '{base: 10'd0,    taps: 11'd8,    rnd: 1'b1, pulse_at: -1, exp_done: -1,   exp_busy: -1,   exp_last_addr: 10'd7};
    vecs[2] = '{base: 10'd1022, taps: 11'd4,    rnd: 1'b0, pulse_at: -1, exp_done: 7,    exp_busy: 6,    exp_last_addr: 10'd1};
    vecs[3] = '{base: 10'd77,   taps: 11'd0,    rnd: 1'b0, pulse_at: -1, exp_done: 1,    exp_busy: 0,    exp_last_addr: 10'd0};
    vecs[4] = '{base: 10'd200,  taps: 11'd6,    rnd: 1'b0, pulse_at: 2,  exp_done: 9,    exp_busy: 8,    exp_last_addr: 10'd205};
    vecs[5] = '{base: 10'd512,  taps: 11'd1024, rnd: 1'b0, pulse_at: -1, exp_done: 1027, exp_busy: 1026, exp_last_addr: 10'd511};
    vecs[6] = '{base: 10'd1020, taps: 11'd9,    rnd: 1'b1, pulse_at: -1, exp_done: -1,   exp_busy: -1,   exp_last_addr: 10'd4};

    #2;
    check("reset_outputs", {busy_o, done_o, enb_o, addrb_o, coeff_o, coeff_valid_o, coeff_last_o, coeff_idx_o}, '0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) run_seq(vecs[i]);

    // Reset in the middle of a 16-tap run, then a clean 2-tap run.
    d0 = done_cnt; h0 = hs_cnt; hit = 1'b0;
    push_expected(10'd50, 11'd16);
    @(posedge clk_i); #1;
    base_addr = 10'd50; num_taps = 11'd16; start = 1'b1; ready = 1'b1;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(posedge clk_i); #1;
      start = 1'b0;
      #5 hit = (hs_cnt - h0 >= 5);
    end
    check("reset_run_reached_5", hit, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("midrun_reset_outputs", {busy_o, done_o, enb_o, addrb_o, coeff_o, coeff_valid_o, coeff_last_o, coeff_idx_o}, '0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #6;
    check("no_done_after_reset", done_cnt - d0, 0);
    run_seq('{base: 10'd300, taps: 11'd2, rnd: 1'b0, pulse_at: -1, exp_done: 5, exp_busy: 4, exp_last_addr: 10'd301});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/student_coeff_reader.md
Name: student_coeff_reader

Overview:
- Read-side sequencer for the coefficient dual-port RAM.
- On a start command, fetches num_taps coefficients from base_addr through the RAM's independent read port (enb/addrb/dob).
- Streams them to the FIR MAC datapath over a valid/ready interface, with last-tap marking and a done pulse.
- Absorbs the RAM's 1-cycle read latency and MAC backpressure with a 2-entry output FIFO; no coefficient is ever dropped or duplicated.

Parameters:
- AddrWidth, 10, RAM address width; RAM depth is 2**AddrWidth.
- CoeffDataSize, 16, coefficient width in bits.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  start request; sampled only in IDLE.
- base_addr_i  input  AddrWidth  first RAM address; latched on accepted start.
- num_taps_i  input  AddrWidth+1  number of coefficients, 0..2**AddrWidth; latched on accepted start.
- busy_o  input-independent output  1  high from the cycle after an accepted start until done.
- done_o  output  1  single-cycle pulse when the sequence completes.
- enb_o  output  1  RAM read enable.
- addrb_o  output  AddrWidth  RAM read address.
- dob_i  input  CoeffDataSize  RAM read data; valid the cycle after enb_o.
- coeff_o  output  CoeffDataSize  coefficient to the MAC.
- coeff_valid_o  output  1  coeff_o valid.
- coeff_ready_i  input  1  MAC accepts the coefficient.
- coeff_last_o  output  1  high with the final coefficient of the sequence.
- coeff_idx_o  output  AddrWidth  tap index 0..num_taps-1 of coeff_o.

Behaviour:
- Reset (async, rst_ni low):
  - All outputs are 0 and state is IDLE.
  - FIFO is emptied; issue, accept and in-flight counters are cleared.
  - Reset mid-sequence aborts it. No done pulse. Any RAM data still in flight is discarded.
- States:
  - IDLE: start_i=1 latches base_addr_i and num_taps_i. Goes to RUN, or to FINISH if num_taps_i==0.
  - RUN: issues reads, fills the FIFO, delivers coefficients. Goes to FINISH in the cycle the last coefficient handshakes (coeff_valid_o && coeff_ready_i && coeff_last_o).
  - FINISH: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
  - start_i outside IDLE is ignored; it is not queued.
- busy_o = (state==RUN). It is 0 in IDLE and in FINISH.
- Read issue:
  - enb_o is combinational: state==RUN && issued<num_taps && (fifo_count + inflight - pop) < 2, where pop = coeff_valid_o && coeff_ready_i.
  - addrb_o is a registered pointer. It starts at base_addr and increments by 1 on each issue, wrapping modulo 2**AddrWidth (e.g. base 1022, 4 taps reads 1022, 1023, 0, 1).
  - addrb_o holds its value when enb_o=0.
- In-flight tracking:
  - inflight is a register equal to enb_o from the previous cycle.
  - When inflight=1, dob_i is pushed into the FIFO at the end of that cycle, together with its tap index and its last flag (index==num_taps-1).
- FIFO:
  - 2 entries. Its head drives coeff_o, coeff_idx_o and coeff_last_o.
  - coeff_valid_o = (fifo_count != 0).
  - Push and pop in the same cycle are legal and leave the count unchanged.
  - Overflow is impossible by the issue rule; the bench asserts this.
  - Head outputs stay stable while coeff_valid_o && !coeff_ready_i.
- Latency and throughput:
  - Start in cycle 0 → enb_o in cycle 1 → dob_i in cycle 2 → coeff_valid_o in cycle 3.
  - With coeff_ready_i held high: 1 coefficient per cycle.
  - Last handshake in cycle N → done_o in cycle N+1.
- num_taps=2**AddrWidth: reads the whole RAM once, starting at base_addr with wrap-around. coeff_idx_o covers 0..2**AddrWidth-1.
- After an accepted start, base_addr_i and num_taps_i may change freely without effect.

Test Plan:
- Basic run: mem[i]=16'h1000+i, base=0, taps=4, ready=1 → enb_o in cycles 1-4 with addrb 0,1,2,3. coeff_o 1000,1001,1002,1003 in cycles 3-6. last=1 only on 1003. done_o in cycle 7. busy_o high in cycles 1-6.
- Backpressure: taps=8, ready toggles 1,0,0,1,... (random) → exactly 8 handshakes, values in order, no duplicates. fifo_count never exceeds 2. coeff_o is stable while stalled.
- Wrap-around: base=1022, taps=4 → addrb 1022,1023,0,1. coeff_idx_o 0..3. last on idx 3.
- Zero taps / ignored start: taps=0 → no enb_o, done_o one cycle after start. start_i pulsed during RUN → no effect on the ongoing sequence, and no second run.
- Reset mid-run: taps=16, assert rst_ni low after 5 handshakes → all outputs 0 immediately, no done_o. A new start with taps=2 then delivers the correct 2 coefficients.
- Full depth: taps=1024, base=512, ready=1 → 1024 consecutive handshakes in 1024 cycles. The final address is 511. done_o follows once.
